// File: rtl/lsu.sv
// Load/store unit: accepts one RV32I memory op at a time from execute,
// checks alignment/encoding, drives a single-beat memory handshake with a
// timeout, formats load data and returns one response toward writeback.
module lsu #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_fault
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MEM  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Last counter value before the wait is declared a fault.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  lane_q, lane_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_valid_q, mem_valid_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic [4:0]  resp_rd_q, resp_rd_d;
   logic        resp_fault_q, resp_fault_d;

   logic        req_fault;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   // Reject unsupported encodings and misaligned halfword/word accesses.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      req_fault = 1'b0;
      if (req_store) begin
         req_fault = (req_funct3 >= 3'b011);
      end else begin
         req_fault = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
      end
      if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
         req_fault = 1'b1;
      end
      if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
         req_fault = 1'b1;
      end
   end

   // Replicate store data across lanes and place the byte strobes.
   always_comb begin
      st_wdata = req_wdata;
      st_wstrb = 4'b1111;
      case (req_funct3[1:0])
         2'b00: begin
            st_wdata = {4{req_wdata[7:0]}};
            st_wstrb = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{req_wdata[15:0]}};
            st_wstrb = 4'b0011 << req_addr[1:0];
         end
         default: ;
      endcase
      if (!req_store) begin
         st_wstrb = 4'b0000;
      end
   end

   // Pick the addressed byte/halfword of the returned word and extend it.
   always_comb begin
      ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
      ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = mem_rdata;
      endcase
   end

   // Next-state logic for the IDLE -> MEM -> RESP sequence.
   always_comb begin
      state_d      = state_q;
      funct3_d     = funct3_q;
      lane_d       = lane_q;
      cnt_d        = cnt_q;
      mem_valid_d  = mem_valid_q;
      mem_we_d     = mem_we_q;
      mem_wstrb_d  = mem_wstrb_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      resp_rd_d    = resp_rd_q;
      resp_fault_d = resp_fault_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               funct3_d  = req_funct3;
               lane_d    = req_addr[1:0];
               resp_rd_d = req_rd;
               if (req_fault) begin
                  // Bad op never reaches memory; report it directly.
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
                  resp_data_d  = 32'h0;
               end else begin
                  state_d     = S_MEM;
                  cnt_d       = 8'h0;
                  mem_valid_d = 1'b1;
                  mem_we_d    = req_store;
                  mem_wstrb_d = st_wstrb;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_wdata_d = st_wdata;
               end
            end
         end
         S_MEM: begin
            // Completion takes priority over a timeout on the same cycle.
            if (mem_ready) begin
               state_d      = S_RESP;
               mem_valid_d  = 1'b0;
               resp_valid_d = 1'b1;
               resp_fault_d = 1'b0;
               resp_data_d  = mem_we_q ? 32'h0 : ld_data;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d      = S_RESP;
               mem_valid_d  = 1'b0;
               resp_valid_d = 1'b1;
               resp_fault_d = 1'b1;
               resp_data_d  = 32'h0;
            end else begin
               cnt_d = cnt_q + 8'h1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (reset) begin
         state_q      <= S_IDLE;
         funct3_q     <= 3'b000;
         lane_q       <= 2'b00;
         cnt_q        <= 8'h0;
         mem_valid_q  <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_wstrb_q  <= 4'b0000;
         mem_addr_q   <= 32'h0;
         mem_wdata_q  <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 32'h0;
         resp_rd_q    <= 5'd0;
         resp_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         funct3_q     <= funct3_d;
         lane_q       <= lane_d;
         cnt_q        <= cnt_d;
         mem_valid_q  <= mem_valid_d;
         mem_we_q     <= mem_we_d;
         mem_wstrb_q  <= mem_wstrb_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_rd_q    <= resp_rd_d;
         resp_fault_q <= resp_fault_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign mem_valid  = mem_valid_q;
   assign mem_we     = mem_we_q;
   assign mem_wstrb  = mem_wstrb_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_rd    = resp_rd_q;
   assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: vector table of single ops plus hand-written sequences for
// timeout, reset abort and back-to-back requests; responses are checked
// against a queue of expected results pushed when each request is driven.
module tb_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_fault;

   lsu #(.TIMEOUT(255)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_rd     (req_rd),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_we     (mem_we),
      .mem_wstrb  (mem_wstrb),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_rd    (resp_rd),
      .resp_fault (resp_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        store;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [4:0]  rd;
      int          delay;
      logic        fault;
      logic [31:0] maddr;
      logic [3:0]  wstrb;
      logic [31:0] mwdata;
      logic [31:0] data;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        fault;
   } exp_t;

   localparam int NVEC = 17;

   vec_t vecs[NVEC];
   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic [4:0] rd,
                               input int dly, input logic flt,
                               input logic [31:0] maddr, input logic [3:0] strb,
                               input logic [31:0] mwd, input logic [31:0] dat);
      vec_t v;
      v.store = st;   v.funct3 = f3;  v.addr = addr;   v.wdata = wdata;
      v.rdata = rdata; v.rd = rd;     v.delay = dly;   v.fault = flt;
      v.maddr = maddr; v.wstrb = strb; v.mwdata = mwd; v.data = dat;
      return v;
   endfunction

   // Called at a negedge where resp_valid should be high: pop and compare.
   task automatic expect_resp(input string name);
      exp_t e;
      check({name, "_resp_valid"}, 32'(resp_valid), 32'd1);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_scoreboard: got response with empty queue, expected none", name);
      end else begin
         e = exp_q.pop_front();
         check({name, "_resp_rd"}, 32'(resp_rd), 32'(e.rd));
         check({name, "_resp_data"}, resp_data, e.data);
         check({name, "_resp_fault"}, 32'(resp_fault), 32'(e.fault));
      end
   endtask

   // Wait (bounded) for resp_valid, check it, then check it was a single pulse.
   task automatic wait_resp(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (resp_valid) break;
         @(negedge clk);
      end
      if (resp_valid) begin
         expect_resp(name);
      end else begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: got no resp_valid, expected one within %0d cycles", name, budget);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(negedge clk);
      check({name, "_pulse_end"}, 32'(resp_valid), 32'd0);
      check({name, "_back_idle"}, 32'(req_ready), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string nm;
      nm = $sformatf("v%0d", idx);
      check({nm, "_ready"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_store  = v.store;
      req_funct3 = v.funct3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      req_rd     = v.rd;
      mem_rdata  = v.rdata;
      exp_q.push_back('{v.rd, v.data, v.fault});
      @(negedge clk);
      req_valid = 1'b0;
      if (v.fault) begin
         check({nm, "_no_mem_valid"}, 32'(mem_valid), 32'd0);
      end else begin
         check({nm, "_mem_valid"}, 32'(mem_valid), 32'd1);
         check({nm, "_mem_addr"}, mem_addr, v.maddr);
         check({nm, "_mem_we"}, 32'(mem_we), 32'(v.store));
         check({nm, "_mem_wstrb"}, 32'(mem_wstrb), 32'(v.wstrb));
         if (v.store) check({nm, "_mem_wdata"}, mem_wdata, v.mwdata);
         for (int i = 0; i < v.delay; i++) @(negedge clk);
         check({nm, "_hold_valid"}, 32'(mem_valid), 32'd1);
         check({nm, "_hold_addr"}, mem_addr, v.maddr);
         mem_ready = 1'b1;
         @(negedge clk);
         mem_ready = 1'b0;
         check({nm, "_mem_drop"}, 32'(mem_valid), 32'd0);
      end
      wait_resp(nm, 4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //                 st    f3      addr          wdata         rdata         rd  dly flt maddr         strb     mwdata        data
      vecs[0]  = mk(1'b0, 3'b000, 32'h80000003, 32'h00000000, 32'h80FF1234, 5'd1, 0, 1'b0, 32'h80000000, 4'b0000, 32'h0, 32'hFFFFFF80);
      vecs[1]  = mk(1'b1, 3'b001, 32'h80000002, 32'h0000BEEF, 32'hDEADBEEF, 5'd2, 1, 1'b0, 32'h80000000, 4'b1100, 32'hBEEFBEEF, 32'h0);
      vecs[2]  = mk(1'b0, 3'b010, 32'h80000006, 32'h00000000, 32'h12345678, 5'd3, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);
      vecs[3]  = mk(1'b0, 3'b001, 32'h00000002, 32'h00000000, 32'h80017FFF, 5'd4, 2, 1'b0, 32'h00000000, 4'b0000, 32'h0, 32'hFFFF8001);
      vecs[4]  = mk(1'b0, 3'b101, 32'h00000010, 32'h00000000, 32'hA5A5C3C3, 5'd5, 254, 1'b0, 32'h00000010, 4'b0000, 32'h0, 32'h0000C3C3);
      vecs[5]  = mk(1'b0, 3'b100, 32'h00001235, 32'h00000000, 32'h1122F344, 5'd6, 0, 1'b0, 32'h00001234, 4'b0000, 32'h0, 32'h000000F3);
      vecs[6]  = mk(1'b0, 3'b000, 32'h00000041, 32'h00000000, 32'h00007F00, 5'd7, 0, 1'b0, 32'h00000040, 4'b0000, 32'h0, 32'h0000007F);
      vecs[7]  = mk(1'b1, 3'b000, 32'h00000203, 32'h12345678, 32'hDEADBEEF, 5'd8, 0, 1'b0, 32'h00000200, 4'b1000, 32'h78787878, 32'h0);
      vecs[8]  = mk(1'b1, 3'b010, 32'h00000300, 32'hCAFEF00D, 32'hDEADBEEF, 5'd9, 3, 1'b0, 32'h00000300, 4'b1111, 32'hCAFEF00D, 32'h0);
      vecs[9]  = mk(1'b1, 3'b001, 32'h00000101, 32'h00001111, 32'h0, 5'd10, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);
      vecs[10] = mk(1'b1, 3'b011, 32'h00000000, 32'h00002222, 32'h0, 5'd11, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);
      vecs[11] = mk(1'b0, 3'b110, 32'h00000000, 32'h00000000, 32'h0, 5'd12, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);
      vecs[12] = mk(1'b0, 3'b011, 32'h00000008, 32'h00000000, 32'h0, 5'd13, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);
      vecs[13] = mk(1'b0, 3'b010, 32'h00007FFC, 32'h00000000, 32'h01020304, 5'd31, 0, 1'b0, 32'h00007FFC, 4'b0000, 32'h0, 32'h01020304);
      vecs[14] = mk(1'b0, 3'b001, 32'h00000020, 32'h00000000, 32'h1234FFFE, 5'd14, 1, 1'b0, 32'h00000020, 4'b0000, 32'h0, 32'hFFFFFFFE);
      vecs[15] = mk(1'b1, 3'b000, 32'h00000000, 32'h000000AB, 32'hDEADBEEF, 5'd15, 0, 1'b0, 32'h00000000, 4'b0001, 32'hABABABAB, 32'h0);
      vecs[16] = mk(1'b0, 3'b001, 32'h00000003, 32'h00000000, 32'h0, 5'd16, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);

      reset = 1'b1;
      req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
      mem_ready = 1'b0; mem_rdata = 32'h0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_data", resp_data, 32'h0);
      check("rst_resp_rd", 32'(resp_rd), 32'd0);
      check("rst_resp_fault", 32'(resp_fault), 32'd0);
      reset = 1'b0;

      // mem_ready while idle is ignored
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      mem_ready = 1'b0;
      check("idle_ready_resp", 32'(resp_valid), 32'd0);
      check("idle_ready_mem", 32'(mem_valid), 32'd0);
      check("idle_ready_rdy", 32'(req_ready), 32'd1);

      for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

      // Timeout: LHU with mem_ready withheld for 255 MEM cycles
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b101;
      req_addr = 32'h10; req_rd = 5'd20; mem_rdata = 32'h5555AAAA;
      exp_q.push_back('{5'd20, 32'h0, 1'b1});
      @(negedge clk);
      req_valid = 1'b0;
      check("to_mem_valid", 32'(mem_valid), 32'd1);
      repeat (254) @(negedge clk);
      check("to_still_waiting", 32'(mem_valid), 32'd1);
      check("to_no_early_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      mem_ready = 1'b1;  // arrives after the fault; must be ignored
      check("to_mem_drop", 32'(mem_valid), 32'd0);
      expect_resp("to");
      @(negedge clk);
      mem_ready = 1'b0;
      check("to_pulse_end", 32'(resp_valid), 32'd0);
      check("to_back_idle", 32'(req_ready), 32'd1);
      @(negedge clk);
      check("to_late_ready_ignored", 32'(resp_valid), 32'd0);

      // Reset while mem_valid is high, with a competing request
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h400; req_rd = 5'd21;
      @(negedge clk);
      check("ra_mem_valid", 32'(mem_valid), 32'd1);
      reset = 1'b1; req_addr = 32'h500; mem_ready = 1'b1;
      @(negedge clk);
      check("ra_mem_valid_low", 32'(mem_valid), 32'd0);
      check("ra_req_ready", 32'(req_ready), 32'd1);
      check("ra_no_resp", 32'(resp_valid), 32'd0);
      check("ra_mem_addr", mem_addr, 32'h0);
      reset = 1'b0; req_valid = 1'b0; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("ra_quiet%0d", i), 32'({resp_valid, mem_valid}), 32'd0);
      end

      // Back-to-back: req_valid held high across op A into op B
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h100; req_rd = 5'd3; mem_rdata = 32'h11223344;
      exp_q.push_back('{5'd3, 32'h11223344, 1'b0});
      exp_q.push_back('{5'd4, 32'hFFFFFFA5, 1'b0});
      @(negedge clk);
      check("b2b_a_mem_valid", 32'(mem_valid), 32'd1);
      check("b2b_a_mem_addr", mem_addr, 32'h100);
      req_funct3 = 3'b000; req_addr = 32'h181; req_rd = 5'd4;
      check("b2b_busy", 32'(req_ready), 32'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      expect_resp("b2b_a");
      check("b2b_resp_busy", 32'(req_ready), 32'd0);
      mem_rdata = 32'h0000A500;
      @(negedge clk);
      check("b2b_idle_ready", 32'(req_ready), 32'd1);
      check("b2b_not_queued", 32'(mem_valid), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_b_mem_valid", 32'(mem_valid), 32'd1);
      check("b2b_b_mem_addr", mem_addr, 32'h180);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      expect_resp("b2b_b");
      @(negedge clk);
      check("b2b_pulse_end", 32'(resp_valid), 32'd0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
